// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, logical/arithmetic shift,
// rotate and a counted multi-step shift with start/busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             din_l,
  input  logic             din_r,
  input  logic [WIDTH-1:0] pdata,
  input  logic             load,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] M_SHL = 3'b001;
  localparam logic [2:0] M_SHR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [2:0] M_ASR = 3'b101;

  state_t           state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [2:0]       mode_r, mode_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] v,
    input logic [2:0]       m,
    input logic             dl,
    input logic             dr
  );
    logic [WIDTH-1:0] r;
    r = v;
    unique case (1'b1)
      (m == M_SHL): r = {v[WIDTH-2:0], dl};
      (m == M_SHR): r = {dr, v[WIDTH-1:1]};
      (m == M_ROL): r = {v[WIDTH-2:0], v[WIDTH-1]};
      (m == M_ROR): r = {v[0], v[WIDTH-1:1]};
      (m == M_ASR): r = {v[WIDTH-1], v[WIDTH-1:1]};
      default:      r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_r;
    q_n     = q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          q_n = pdata;
        end else if (start && (amt != '0)) begin
          mode_n  = mode;
          cnt_n   = amt;
          state_n = RUN;
        end else if (start) begin
          done_n = 1'b1;
        end else begin
          q_n = step(q, mode, din_l, din_r);
        end
      end
      RUN: begin
        // Latched mode drives the steps; din is still sampled live.
        q_n   = step(q, mode_r, din_l, din_r);
        cnt_n = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= '0;
      q      <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_r <= mode_n;
      q      <= q_n;
      done   <= done_n;
    end
  end

  assign busy   = (state == RUN);
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: 8-bit and 16-bit instances against a
// per-cycle behavioural model plus hand-computed literal checks.
module tb_univ_shift_reg;

  logic        clk;
  logic        reset;
  logic [2:0]  mode;
  logic        din_l, din_r, load, start;
  logic [7:0]  pdata8;
  logic [3:0]  amt8;
  logic [15:0] pdata16;
  logic [4:0]  amt16;

  logic [7:0]  q8;
  logic        sl8, sr8, busy8, done8;
  logic [15:0] q16;
  logic        sl16, sr16, busy16, done16;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut8 (
    .clk(clk), .reset(reset), .mode(mode),
    .din_l(din_l), .din_r(din_r), .pdata(pdata8),
    .load(load), .start(start), .amt(amt8),
    .q(q8), .sout_l(sl8), .sout_r(sr8),
    .busy(busy8), .done(done8)
  );

  univ_shift_reg #(.WIDTH(16), .AMT_W(5)) dut16 (
    .clk(clk), .reset(reset), .mode(mode),
    .din_l(din_l), .din_r(din_r), .pdata(pdata16),
    .load(load), .start(start), .amt(amt16),
    .q(q16), .sout_l(sl16), .sout_r(sr16),
    .busy(busy16), .done(done16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] q;
    bit          busy;
    int          left;
    logic [2:0]  op;
    bit          done;
  } mst_t;

  mst_t m8, m16;

  function automatic logic [31:0] stp(
    input logic [31:0] v, input int w, input logic [2:0] op,
    input logic dl, input logic dr);
    logic [31:0] msb, mask;
    msb  = 32'd1 << (w - 1);
    mask = (msb << 1) - 32'd1;
    case (op)
      3'd1:    return ((v << 1) | 32'(dl)) & mask;
      3'd2:    return (v >> 1) | (dr ? msb : 32'd0);
      3'd3:    return ((v << 1) | (v >> (w - 1))) & mask;
      3'd4:    return (v >> 1) | (v[0] ? msb : 32'd0);
      3'd5:    return (v >> 1) | (v & msb);
      default: return v;
    endcase
  endfunction

  function automatic mst_t nxt(
    input mst_t s, input int w, input int a, input logic [31:0] pd);
    mst_t n;
    n = s;
    n.done = 1'b0;
    if (!s.busy) begin
      if (load) n.q = pd;
      else if (start && a != 0) begin
        n.busy = 1'b1;
        n.left = a;
        n.op   = mode;
      end else if (start) n.done = 1'b1;
      else n.q = stp(s.q, w, mode, din_l, din_r);
    end else begin
      n.q    = stp(s.q, w, s.op, din_l, din_r);
      n.left = s.left - 1;
      if (n.left == 0) begin
        n.busy = 1'b0;
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("q8", 32'(q8), m8.q);
    chk("busy8", 32'(busy8), 32'(m8.busy));
    chk("done8", 32'(done8), 32'(m8.done));
    chk("soutl8", 32'(sl8), 32'(m8.q[7]));
    chk("soutr8", 32'(sr8), 32'(m8.q[0]));
    chk("q16", 32'(q16), m16.q);
    chk("busy16", 32'(busy16), 32'(m16.busy));
    chk("done16", 32'(done16), 32'(m16.done));
    chk("soutl16", 32'(sl16), 32'(m16.q[15]));
    chk("soutr16", 32'(sr16), 32'(m16.q[0]));
  endtask

  task automatic mreset();
    m8  = '{q: 32'd0, busy: 1'b0, left: 0, op: 3'd0, done: 1'b0};
    m16 = '{q: 32'd0, busy: 1'b0, left: 0, op: 3'd0, done: 1'b0};
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) mreset();
    else begin
      m8  = nxt(m8, 8, int'(amt8), 32'(pdata8));
      m16 = nxt(m16, 16, int'(amt16), 32'(pdata16));
    end
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    reset = 1'b0; mode = 3'd0; din_l = 1'b0; din_r = 1'b0;
    load = 1'b0; start = 1'b0;
    pdata8 = 8'h00; amt8 = 4'd0; pdata16 = 16'h0000; amt16 = 5'd0;
    mreset();
    tick(); tick();
    chk("rst_q", 32'(q8), 32'h00);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);

    reset = 1'b1;
    load = 1'b1; pdata8 = 8'hA5; pdata16 = 16'h1234;
    tick();
    chk("load_a5", 32'(q8), 32'hA5);
    start = 1'b1; pdata8 = 8'h3C; amt8 = 4'd2; amt16 = 5'd2;
    tick();
    chk("load_start_q", 32'(q8), 32'h3C);
    chk("load_start_busy", 32'(busy8), 32'd0);

    start = 1'b0; pdata8 = 8'h00; pdata16 = 16'h0000;
    tick();
    load = 1'b0; mode = 3'b001; din_l = 1'b1;
    repeat (3) tick();
    chk("shl3_q", 32'(q8), 32'h07);
    chk("shl3_soutr", 32'(sr8), 32'd1);
    mode = 3'b010; din_r = 1'b0;
    repeat (2) tick();
    chk("shr2_q", 32'(q8), 32'h01);

    mode = 3'b000; load = 1'b1; pdata8 = 8'h81;
    tick();
    load = 1'b0; start = 1'b1; mode = 3'b011;
    amt8 = 4'd3; amt16 = 5'd3;
    tick();
    chk("rol_busy", 32'(busy8), 32'd1);
    start = 1'b0; mode = 3'b000; load = 1'b1; pdata8 = 8'hFF;
    tick(); tick();
    chk("rol_busy_mid", 32'(busy8), 32'd1);
    load = 1'b0;
    tick();
    chk("rol_done", 32'(done8), 32'd1);
    chk("rol_q", 32'(q8), 32'h0C);
    chk("rol_busy_end", 32'(busy8), 32'd0);
    tick();
    chk("rol_done_clr", 32'(done8), 32'd0);

    load = 1'b1; pdata8 = 8'h90;
    tick();
    load = 1'b0; start = 1'b1; mode = 3'b101;
    amt8 = 4'd2; amt16 = 5'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("asr_done", 32'(done8), 32'd1);
    chk("asr_q", 32'(q8), 32'hE4);
    start = 1'b1; mode = 3'b001; din_l = 1'b0;
    amt8 = 4'd1; amt16 = 5'd1;
    tick();
    chk("b2b_busy", 32'(busy8), 32'd1);
    chk("b2b_done_low", 32'(done8), 32'd0);
    start = 1'b0;
    tick();
    chk("b2b_done", 32'(done8), 32'd1);
    chk("b2b_q", 32'(q8), 32'hC8);

    mode = 3'b000; start = 1'b1; amt8 = 4'd0; amt16 = 5'd0;
    tick();
    chk("amt0_done", 32'(done8), 32'd1);
    chk("amt0_busy", 32'(busy8), 32'd0);
    chk("amt0_q", 32'(q8), 32'hC8);
    start = 1'b0;
    tick();
    chk("amt0_done_clr", 32'(done8), 32'd0);

    start = 1'b1; mode = 3'b001; din_l = 1'b1;
    amt8 = 4'd5; amt16 = 5'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    mreset();
    #1;
    cmp_all();
    chk("abort_q", 32'(q8), 32'h00);
    chk("abort_busy", 32'(busy8), 32'd0);
    tick();
    reset = 1'b1; mode = 3'b000;
    repeat (4) tick();
    chk("abort_nodone", 32'(done8), 32'd0);

    load = 1'b1; pdata16 = 16'h0001;
    tick();
    load = 1'b0; start = 1'b1; mode = 3'b100;
    amt16 = 5'd17; amt8 = 4'd0;
    tick();
    start = 1'b0;
    repeat (17) tick();
    chk("wrap_done", 32'(done16), 32'd1);
    chk("wrap_q", 32'(q16), 32'h8000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
